conv_fprop2_udiv_16ns_6ns_16_seq: RTL and testbench

CONV_FPROP2_UDIV_16NS_6NS_16_SEQ -- requirements
Module: conv_fprop2_udiv_16ns_6ns_16_seq

---
 rtl/conv_fprop2_pkg.sv | 21 ++
 rtl/conv_fprop2_udiv_step.sv | 25 ++
 rtl/conv_fprop2_udiv_16ns_6ns_16_seq.sv | 92 +++++++++
 tb/tb_conv_fprop2_udiv_16ns_6ns_16_seq.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_fprop2_pkg.sv
// Shared types and sizing for the conv_fprop2 sequential divider.
package conv_fprop2_pkg;

  // Divider control states; no other encodings are used.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DIN0_WIDTH_DEFAULT = 16;

  // Iteration counter width for the default dividend width.
  localparam int unsigned CNT_WIDTH = $clog2(DIN0_WIDTH_DEFAULT + 1);

  // Counter width for an arbitrary dividend width.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/conv_fprop2_udiv_step.sv
// One radix-2 restoring division step (purely combinational).
module conv_fprop2_udiv_step #(
  parameter int unsigned din1_WIDTH = 6
) (
  input  logic [din1_WIDTH:0]   rem_i,
  input  logic                  bit_i,
  input  logic [din1_WIDTH-1:0] div_i,
  output logic [din1_WIDTH:0]   rem_o,
  output logic                  q_o
);

  logic [din1_WIDTH+1:0] shifted;
  logic [din1_WIDTH:0]   diff;

  // Shift in the next dividend bit, subtract the divisor when it fits.
  // The compare uses the full shifted value; with a zero divisor the top
  // bit falls off the kept remainder, leaving the low dividend bits.
  always_comb begin
    shifted = {rem_i, bit_i};
    q_o     = (shifted >= {2'b00, div_i});
    diff    = shifted[din1_WIDTH:0] - {1'b0, div_i};
    rem_o   = q_o ? diff : shifted[din1_WIDTH:0];
  end

endmodule

// File: rtl/conv_fprop2_udiv_16ns_6ns_16_seq.sv
// Sequential unsigned divider: din0_WIDTH restoring steps per division,
// valid/ready handshakes on both operand and result sides.
module conv_fprop2_udiv_16ns_6ns_16_seq
  import conv_fprop2_pkg::*;
#(
  parameter int unsigned din0_WIDTH = 16,
  parameter int unsigned din1_WIDTH = 6,
  parameter int unsigned dout_WIDTH = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  dbz
);

  localparam int unsigned CntW = cnt_width(din0_WIDTH);
  localparam logic [CntW-1:0] LastStep = CntW'(din0_WIDTH - 1);

  state_e                  state_q;
  logic [CntW-1:0]         cnt_q;
  // Dividend bits shift out at the MSB while quotient bits enter at the LSB.
  logic [din0_WIDTH-1:0]   dq_q;
  logic [din1_WIDTH-1:0]   div_q;
  logic [din1_WIDTH:0]     rem_q;
  logic                    dbz_q;

  logic [din1_WIDTH:0]     rem_d;
  logic                    qbit_d;

  conv_fprop2_udiv_step #(
    .din1_WIDTH(din1_WIDTH)
  ) u_step (
    .rem_i (rem_q),
    .bit_i (dq_q[din0_WIDTH-1]),
    .div_i (div_q),
    .rem_o (rem_d),
    .q_o   (qbit_d)
  );

  // Control FSM, iteration counter and datapath registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dq_q    <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_vld) begin
            dq_q    <= din0;
            div_q   <= din1;
            rem_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= (din1 == '0);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          dq_q  <= {dq_q[din0_WIDTH-2:0], qbit_d};
          rem_q <= rem_d;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == LastStep) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_rdy) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_rdy  = (state_q == IDLE);
  assign out_vld = (state_q == DONE);
  assign dout    = dout_WIDTH'(dq_q);
  assign rem     = rem_q[din1_WIDTH-1:0];
  assign dbz     = dbz_q;

endmodule

// File: tb/tb_conv_fprop2_udiv_16ns_6ns_16_seq.sv
// Self-checking bench for the sequential divider against an integer model.
module tb_conv_fprop2_udiv_16ns_6ns_16_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [15:0] din0 = '0;
  logic [5:0]  din1 = '0;
  logic        out_vld;
  logic        out_rdy = 1'b0;
  logic [15:0] dout;
  logic [5:0]  rem;
  logic        dbz;

  int unsigned vectors = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [15:0] q;
    logic [5:0]  r;
    logic        d;
  } exp_t;

  conv_fprop2_udiv_16ns_6ns_16_seq #(
    .din0_WIDTH(16),
    .din1_WIDTH(6),
    .dout_WIDTH(16)
  ) dut (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .din0    (din0),
    .din1    (din1),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .dout    (dout),
    .rem     (rem),
    .dbz     (dbz)
  );

  always #5 ap_clk = ~ap_clk;

  // Integer-division reference with the divide-by-zero convention.
  function automatic exp_t model(input logic [15:0] a, input logic [5:0] b);
    exp_t e;
    int unsigned ai;
    int unsigned bi;
    ai = a;
    bi = b;
    if (bi == 0) begin
      e.q = 16'hFFFF;
      e.r = a[5:0];
      e.d = 1'b1;
    end else begin
      e.q = 16'(ai / bi);
      e.r = 6'(ai % bi);
      e.d = 1'b0;
    end
    return e;
  endfunction

  // Present operands, let them be accepted, then count cycles to out_vld.
  task automatic accept_and_wait(input logic [15:0] a, input logic [5:0] b,
                                 output bit rdy_seen, output int lat);
    @(negedge ap_clk);
    in_vld = 1'b1;
    din0 = a;
    din1 = b;
    rdy_seen = in_rdy;
    @(posedge ap_clk);
    @(negedge ap_clk);
    in_vld = 1'b0;
    din0 = 16'($urandom);
    din1 = 6'($urandom);
    lat = 0;
    while (!out_vld && lat < 40) begin
      @(negedge ap_clk);
      lat++;
    end
  endtask

  task automatic handshake();
    out_rdy = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    out_rdy = 1'b0;
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    #1;
    vectors++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy got %b want 1", in_rdy); end
    vectors++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld got %b want 0", out_vld); end
    vectors++; if (dout !== 16'h0) begin errors++; $display("FAIL reset_dout got %h want 0", dout); end
    vectors++; if (rem !== 6'h0) begin errors++; $display("FAIL reset_rem got %h want 0", rem); end
    vectors++; if (dbz !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", dbz); end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] a_tab [4] = '{16'd1000, 16'd65535, 16'd5, 16'd1234};
    logic [5:0]  b_tab [4] = '{6'd7, 6'd63, 6'd9, 6'd0};
    logic [15:0] q_tab [4] = '{16'd142, 16'd1040, 16'd0, 16'hFFFF};
    logic [5:0]  r_tab [4] = '{6'd6, 6'd15, 6'd5, 6'd18};
    logic        d_tab [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    bit rdy;
    int lat;
    for (int i = 0; i < 4; i++) begin
      accept_and_wait(a_tab[i], b_tab[i], rdy, lat);
      vectors++; if (rdy !== 1'b1) begin errors++; $display("FAIL dir%0d_in_rdy got %b want 1", i, rdy); end
      vectors++; if (lat != 16) begin errors++; $display("FAIL dir%0d_latency got %0d want 16", i, lat); end
      vectors++; if (dout !== q_tab[i]) begin errors++; $display("FAIL dir%0d_dout got %0d want %0d", i, dout, q_tab[i]); end
      vectors++; if (rem !== r_tab[i]) begin errors++; $display("FAIL dir%0d_rem got %0d want %0d", i, rem, r_tab[i]); end
      vectors++; if (dbz !== d_tab[i]) begin errors++; $display("FAIL dir%0d_dbz got %b want %b", i, dbz, d_tab[i]); end
      handshake();
      vectors++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL dir%0d_rdy_after got %b want 1", i, in_rdy); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] a;
    logic [5:0]  b;
    exp_t e;
    bit rdy;
    int lat;
    a = 16'($urandom);
    b = 6'($urandom_range(1, 63));
    e = model(a, b);
    accept_and_wait(a, b, rdy, lat);
    vectors++; if (lat != 16) begin errors++; $display("FAIL bp_latency got %0d want 16", lat); end
    for (int i = 0; i < 10; i++) begin
      vectors++; if (out_vld !== 1'b1) begin errors++; $display("FAIL bp_out_vld cyc %0d got %b want 1", i, out_vld); end
      vectors++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL bp_in_rdy cyc %0d got %b want 0", i, in_rdy); end
      vectors++; if (dout !== e.q || rem !== e.r || dbz !== e.d) begin
        errors++;
        $display("FAIL bp_hold cyc %0d got %0d/%0d/%b want %0d/%0d/%b", i, dout, rem, dbz, e.q, e.r, e.d);
      end
      in_vld = 1'($urandom);
      din0 = 16'($urandom);
      din1 = 6'($urandom);
      @(negedge ap_clk);
    end
    in_vld = 1'b0;
    vectors++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL bp_rdy_before_hs got %b want 0", in_rdy); end
    handshake();
    vectors++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL bp_rdy_after_hs got %b want 1", in_rdy); end
    vectors++; if (out_vld !== 1'b0) begin errors++; $display("FAIL bp_vld_after_hs got %b want 0", out_vld); end
    @(negedge ap_clk);
    vectors++; if (in_rdy !== 1'b1 || out_vld !== 1'b0) begin
      errors++; $display("FAIL bp_idle_stays got rdy %b vld %b want 1 0", in_rdy, out_vld);
    end
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    @(negedge ap_clk);
    in_vld = 1'b1;
    din0 = 16'($urandom);
    din1 = 6'($urandom_range(1, 63));
    @(posedge ap_clk);
    @(negedge ap_clk);
    in_vld = 1'b0;
    repeat (7) @(negedge ap_clk);
    #2;
    ap_rst_n = 1'b0;
    #1;
    vectors++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL mid_rst_in_rdy got %b want 1", in_rdy); end
    vectors++; if (out_vld !== 1'b0) begin errors++; $display("FAIL mid_rst_out_vld got %b want 0", out_vld); end
    vectors++; if (dout !== 16'h0 || rem !== 6'h0 || dbz !== 1'b0) begin
      errors++; $display("FAIL mid_rst_outputs got %h/%h/%b want 0/0/0", dout, rem, dbz);
    end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    in_vld = 1'b1;
    din0 = 16'd300;
    din1 = 6'd10;
    vectors++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL post_rst_in_rdy got %b want 1", in_rdy); end
    @(posedge ap_clk);
    @(negedge ap_clk);
    in_vld = 1'b0;
    lat = 0;
    while (!out_vld && lat < 40) begin
      @(negedge ap_clk);
      lat++;
    end
    vectors++; if (lat != 16) begin errors++; $display("FAIL post_rst_latency got %0d want 16", lat); end
    vectors++; if (dout !== 16'd30) begin errors++; $display("FAIL post_rst_dout got %0d want 30", dout); end
    vectors++; if (rem !== 6'd0) begin errors++; $display("FAIL post_rst_rem got %0d want 0", rem); end
    handshake();
  endtask

  task automatic test_back_to_back();
    localparam int N = 40;
    exp_t expq[$];
    exp_t e;
    int accepts = 0;
    int results = 0;
    int cyc = 0;
    int last_acc = 0;
    int k;
    logic [15:0] a;
    logic [5:0]  b;
    while ((accepts < N || expq.size() != 0) && cyc < 5000) begin
      @(negedge ap_clk);
      cyc++;
      out_rdy = ($urandom_range(0, 3) != 0);
      if (out_vld && out_rdy) begin
        vectors++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected_result got %0d/%0d", dout, rem);
        end else begin
          e = expq.pop_front();
          if (dout !== e.q || rem !== e.r || dbz !== e.d) begin
            errors++;
            $display("FAIL b2b_result #%0d got %0d/%0d/%b want %0d/%0d/%b", results, dout, rem, dbz, e.q, e.r, e.d);
          end
        end
        results++;
      end
      if (in_rdy && accepts < N) begin
        k = $urandom_range(0, 9);
        if (k == 0) begin
          a = 16'($urandom);
          b = 6'd0;
        end else if (k == 1) begin
          a = 16'($urandom_range(0, 62));
          b = 6'($urandom_range(a + 1, 63));
        end else begin
          a = 16'($urandom);
          b = 6'($urandom);
        end
        din0 = a;
        din1 = b;
        in_vld = 1'b1;
        expq.push_back(model(a, b));
        if (accepts > 0) begin
          vectors++;
          if (cyc - last_acc < 18) begin
            errors++; $display("FAIL b2b_spacing got %0d want >=18", cyc - last_acc);
          end
        end
        last_acc = cyc;
        accepts++;
      end else begin
        in_vld = (accepts < N);
        din0 = 16'($urandom);
        din1 = 6'($urandom);
      end
    end
    in_vld = 1'b0;
    out_rdy = 1'b0;
    vectors++; if (cyc >= 5000) begin errors++; $display("FAIL b2b_timeout got %0d cycles want <5000", cyc); end
    vectors++; if (results != N) begin errors++; $display("FAIL b2b_count got %0d want %0d", results, N); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_busy();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
